// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared opcodes, states and iteration counts for div_unit
package div_unit_pkg;

  localparam int ITER_D = 64;
  localparam int ITER_W = 32;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// rtl/div_unit_if.sv - decoder-to-divider request and writeback response handshakes
interface div_unit_if
  import div_unit_pkg::*;
#(
  parameter int XLEN = 64
) ();

  logic            in_valid;
  logic            in_ready;
  div_op_t         in_op;
  logic            in_word;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;

  modport master (
    output in_valid, in_op, in_word, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result
  );

  modport slave (
    input  in_valid, in_op, in_word, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result
  );

endinterface

// File: rtl/div_unit_step.sv
// rtl/div_unit_step.sv - one restoring division iteration (shift, compare, subtract)
module div_unit_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0]   rem_sh;
  logic [XLEN-1:0] diff;
  logic            ge;

  // The partial remainder stays below the divisor, so the restored value fits XLEN bits.
  always_comb begin
    rem_sh = {rem_i, quo_i[XLEN-1]};
    ge     = (rem_sh >= {1'b0, divisor_i});
    diff   = rem_sh[XLEN-1:0] - divisor_i;
    rem_o  = ge ? diff : rem_sh[XLEN-1:0];
    quo_o  = {quo_i[XLEN-2:0], ge};
  end

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative radix-2 restoring divider for RV64M DIV/REM and W variants
// Optional flush port enabled by DIV_UNIT_FLUSH_EN.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic       clk,
  input  logic       reset,
`ifdef DIV_UNIT_FLUSH_EN
  input  logic       flush,
`endif
  div_unit_if.slave  bus
);

  logic [1:0]      state_q, state_d;
  logic [5:0]      count_q, count_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic            neg_q_q, neg_q_d;
  logic            neg_r_q, neg_r_d;
  div_op_t         op_q, op_d;
  logic            word_q, word_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            is_signed;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag;
  logic            a_neg, b_neg, div_zero, ovf;
  logic [XLEN-1:0] sp_sel, sp_res;

  logic [XLEN-1:0] step_rem, step_quo;
  logic [XLEN-1:0] q_raw, q_fix, r_fix, fix_sel, fix_res;

  div_unit_step #(.XLEN(XLEN)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  // Operand preparation and special-case results for the accept cycle.
  always_comb begin
    is_signed = ~bus.in_op[0];
    if (bus.in_word) begin
      a_ext = is_signed ? sext32(bus.in_a[31:0]) : {32'b0, bus.in_a[31:0]};
      b_ext = is_signed ? sext32(bus.in_b[31:0]) : {32'b0, bus.in_b[31:0]};
    end else begin
      a_ext = bus.in_a;
      b_ext = bus.in_b;
    end
    a_neg    = is_signed & a_ext[XLEN-1];
    b_neg    = is_signed & b_ext[XLEN-1];
    a_mag    = a_neg ? (0 - a_ext) : a_ext;
    b_mag    = b_neg ? (0 - b_ext) : b_ext;
    div_zero = (b_ext == '0);
    ovf      = is_signed & (b_ext == '1) &
               (a_ext == (bus.in_word ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}}));
    if (div_zero) sp_sel = bus.in_op[1] ? a_ext : '1;
    else          sp_sel = bus.in_op[1] ? '0 : a_ext;
    sp_res = bus.in_word ? sext32(sp_sel[31:0]) : sp_sel;
  end

  // Sign and width fix-up applied to the final iteration's outputs.
  always_comb begin
    q_raw   = word_q ? {32'b0, step_quo[31:0]} : step_quo;
    q_fix   = neg_q_q ? (0 - q_raw) : q_raw;
    r_fix   = neg_r_q ? (0 - step_rem) : step_rem;
    fix_sel = op_q[1] ? r_fix : q_fix;
    fix_res = word_q ? sext32(fix_sel[31:0]) : fix_sel;
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    op_d     = op_q;
    word_d   = word_q;
    result_d = result_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          op_d    = bus.in_op;
          word_d  = bus.in_word;
          neg_q_d = a_neg ^ b_neg;
          neg_r_d = a_neg;
          if (div_zero || ovf) begin
            state_d  = DONE;
            result_d = sp_res;
          end else begin
            state_d = CALC;
            count_d = bus.in_word ? 6'(ITER_W - 1) : 6'(ITER_D - 1);
            rem_d   = '0;
            // W dividends are left-aligned so every iteration consumes quo_q's MSB.
            quo_d   = bus.in_word ? {a_mag[31:0], 32'b0} : a_mag;
            dvs_d   = b_mag;
          end
        end
      end
      CALC: begin
        rem_d   = step_rem;
        quo_d   = step_quo;
        count_d = count_q - 6'd1;
        if (count_q == 6'd0) begin
          state_d  = DONE;
          count_d  = '0;
          result_d = fix_res;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      op_q     <= DIV;
      word_q   <= 1'b0;
      result_q <= '0;
    end
`ifdef DIV_UNIT_FLUSH_EN
    else if (flush) begin
      state_q <= IDLE;
      count_q <= '0;
    end
`endif
    else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      op_q     <= op_d;
      word_q   <= word_d;
      result_q <= result_d;
    end
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = (state_q == DONE);
  assign bus.out_result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - randomized and directed self-checking bench for div_unit
module tb_div_unit;
  import div_unit_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
`ifdef DIV_UNIT_FLUSH_EN
  logic flush = 1'b0;
`endif

  div_unit_if #(.XLEN(64)) bus ();

  div_unit #(.XLEN(64)) dut (
    .clk   (clk),
    .reset (reset),
`ifdef DIV_UNIT_FLUSH_EN
    .flush (flush),
`endif
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic        exp_live = 1'b0;
  logic [63:0] exp_cur  = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] sx(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // RISC-V M-extension semantics in plain integer arithmetic.
  function automatic logic [63:0] model(input logic [1:0] op, input logic word,
                                        input logic [63:0] a, input logic [63:0] b);
    logic        sgn;
    logic [63:0] q, r;
    sgn = ~op[0];
    if (word) begin
      int          sa, sb;
      int unsigned ua, ub;
      sa = a[31:0]; sb = b[31:0]; ua = a[31:0]; ub = b[31:0];
      if (ub == 0) begin
        q = '1; r = sx(a[31:0]);
      end else if (sgn && sa == 32'sh8000_0000 && sb == -1) begin
        q = sx(a[31:0]); r = '0;
      end else if (sgn) begin
        q = sx(sa / sb); r = sx(sa % sb);
      end else begin
        q = sx(ua / ub); r = sx(ua % ub);
      end
      return op[1] ? sx(r[31:0]) : sx(q[31:0]);
    end else begin
      longint          sa, sb;
      longint unsigned ua, ub;
      sa = a; sb = b; ua = a; ub = b;
      if (ub == 0) begin
        q = '1; r = a;
      end else if (sgn && sa == 64'sh8000_0000_0000_0000 && sb == -1) begin
        q = a; r = '0;
      end else if (sgn) begin
        q = sa / sb; r = sa % sb;
      end else begin
        q = ua / ub; r = ua % ub;
      end
      return op[1] ? r : q;
    end
  endfunction

  function automatic int model_lat(input logic [1:0] op, input logic word,
                                   input logic [63:0] a, input logic [63:0] b);
    logic zero, ovf;
    if (word) begin
      zero = (b[31:0] == 0);
      ovf  = ~op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF;
    end else begin
      zero = (b == 0);
      ovf  = ~op[0] && a == 64'h8000_0000_0000_0000 && b == '1;
    end
    if (zero || ovf) return 1;
    return word ? 33 : 65;
  endfunction

  // Every cycle a result is shown it must match the model and belong to a live operation.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && bus.out_valid) begin
        check("valid_without_op", {63'b0, exp_live}, 64'd1);
        if (exp_live) check("model_result", bus.out_result, exp_cur);
      end
    end
  end

  task automatic start_op(input logic [1:0] op, input logic word,
                          input logic [63:0] a, input logic [63:0] b);
    check("in_ready_idle", {63'b0, bus.in_ready}, 64'd1);
    bus.in_valid = 1'b1;
    bus.in_op    = div_op_t'(op);
    bus.in_word  = word;
    bus.in_a     = a;
    bus.in_b     = b;
    exp_cur      = model(op, word, a, b);
    exp_live     = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_op    = div_op_t'($urandom_range(0, 3));
    bus.in_word  = 1'($urandom_range(0, 1));
    bus.in_a     = {$urandom, $urandom};
    bus.in_b     = {$urandom, $urandom};
  endtask

  task automatic finish_op(input string name, input int exp_lat, input int hold,
                           input logic lit_en, input logic [63:0] lit);
    int   lat;
    logic busy_ok;
    lat = 1;
    busy_ok = 1'b1;
    while (!bus.out_valid && lat < 300) begin
      if (bus.in_ready) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    check({name, "_busy"}, {63'b0, busy_ok}, 64'd1);
    if (lit_en) check(name, bus.out_result, lit);
    repeat (hold) begin
      @(posedge clk); #1;
      check({name, "_hold_valid"}, {63'b0, bus.out_valid}, 64'd1);
      check({name, "_hold_ready"}, {63'b0, bus.in_ready}, 64'd0);
      if (lit_en) check({name, "_hold_result"}, bus.out_result, lit);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    exp_live = 1'b0;
    check({name, "_ready_after"}, {63'b0, bus.in_ready}, 64'd1);
    check({name, "_valid_after"}, {63'b0, bus.out_valid}, 64'd0);
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic word,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic lit_en, input logic [63:0] lit, input int hold);
    start_op(op, word, a, b);
    finish_op(name, model_lat(op, word, a, b), hold, lit_en, lit);
  endtask

  task automatic abort_test(input string name, input logic use_flush);
    start_op(2'b00, 1'b0, {$urandom, $urandom}, 64'd3);
    repeat (19) @(posedge clk);
    #1;
`ifdef DIV_UNIT_FLUSH_EN
    if (use_flush) flush = 1'b1;
    else reset = 1'b1;
`else
    reset = 1'b1;
    if (use_flush) $display("flush unavailable");
`endif
    exp_live = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
`ifdef DIV_UNIT_FLUSH_EN
    flush = 1'b0;
`endif
    check({name, "_in_ready"}, {63'b0, bus.in_ready}, 64'd1);
    check({name, "_out_valid"}, {63'b0, bus.out_valid}, 64'd0);
    run_op({name, "_divu_9_3"}, 2'b01, 1'b0, 64'd9, 64'd3, 1'b1, 64'd3, 0);
  endtask

  initial begin
    logic [1:0]  op;
    logic        word;
    logic [63:0] a, b;
    bus.in_valid  = 1'b0;
    bus.in_op     = DIV;
    bus.in_word   = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", {63'b0, bus.in_ready}, 64'd1);
    check("reset_out_valid", {63'b0, bus.out_valid}, 64'd0);
    check("reset_out_result", bus.out_result, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op("divu_100_7", 2'b01, 1'b0, 64'd100, 64'd7, 1'b1, 64'd14, 0);
    run_op("remu_100_7", 2'b11, 1'b0, 64'd100, 64'd7, 1'b1, 64'd2, 0);
    run_op("div_m7_2", 2'b00, 1'b0, -64'sd7, 64'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 0);
    run_op("rem_m7_2", 2'b10, 1'b0, -64'sd7, 64'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_op("remu_7_m2", 2'b11, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 64'd7, 0);
    run_op("divu_by0", 2'b01, 1'b0, 64'd12345, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run_op("rem_by0", 2'b10, 1'b0, 64'd5, 64'd0, 1'b1, 64'd5, 0);
    run_op("remw_by0", 2'b10, 1'b1, 64'h8000_0000, 64'd0, 1'b1, 64'hFFFF_FFFF_8000_0000, 0);
    run_op("div_ovf", 2'b00, 1'b0, 64'h8000_0000_0000_0000, '1, 1'b1, 64'h8000_0000_0000_0000, 0);
    run_op("rem_ovf", 2'b10, 1'b0, 64'h8000_0000_0000_0000, '1, 1'b1, 64'd0, 0);
    run_op("divw_ovf", 2'b00, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFF_8000_0000, 0);
    run_op("divuw_ff_1", 2'b01, 1'b1, 64'hFFFF_FFFF, 64'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 5);

    for (int i = 0; i < 40; i++) begin
      op   = 2'($urandom_range(0, 3));
      word = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: a = word ? 64'h8000_0000 : 64'h8000_0000_0000_0000;
        1: a = 64'($urandom_range(0, 1000));
        default: a = {$urandom, $urandom};
      endcase
      case ($urandom_range(0, 5))
        0: b = {$urandom, 32'b0};
        1: b = '1;
        2: b = 64'($urandom_range(1, 20));
        3: b = -64'($urandom_range(1, 20));
        default: b = {$urandom, $urandom} >> $urandom_range(0, 60);
      endcase
      run_op("random", op, word, a, b, 1'b0, '0, $urandom_range(0, 3));
    end

    abort_test("reset_mid_op", 1'b0);
`ifdef DIV_UNIT_FLUSH_EN
    abort_test("flush_mid_op", 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
